// File: rtl/bcd_display_mux.sv
// Converts two 14-bit counters to BCD with one shared shift-add-3 engine and scans
// them onto an 8-digit common-anode display (number_1 on digits 3..0, number_2 on 7..4).
module bcd_display_mux #(
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst_ext_n,
    input  logic [13:0] number_1,
    input  logic [13:0] number_2,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          range_q, range_d;
    logic [3:0]    iter_q, iter_d;
    logic [15:0]   bank1_q, bank1_d, bank2_q, bank2_d;
    logic          over1_q, over1_d, over2_q, over2_d;
    logic [PW-1:0] presc_q;
    logic [2:0]    idx_q;
    logic [6:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;
    logic          dp_q, dp_d;

    logic [13:0]   sample;
    logic [15:0]   bcdAdj;
    logic [15:0]   bankSel;
    logic          overSel;
    logic [1:0]    digitPos;
    logic [3:0]    nibble;
    logic          upperZero;

    function automatic logic [15:0] addThree(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int n = 0; n < 4; n++) begin
            if (v[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = v[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] encodeDigit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Conversion engine: the banks only change in STORE, so the scan never sees a partial result.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        range_d = range_q;
        iter_d  = iter_q;
        bank1_d = bank1_q;
        bank2_d = bank2_q;
        over1_d = over1_q;
        over2_d = over2_q;
        sample  = sel_q ? number_2 : number_1;
        bcdAdj  = addThree(bcd_q);
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                bin_d   = sample;
                bcd_d   = 16'd0;
                range_d = (sample > 14'd9999);
                iter_d  = 4'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d  = {bcdAdj[14:0], bin_q[13]};
                bin_d  = {bin_q[12:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) state_d = ST_STORE;
            end
            default: begin
                if (sel_q) begin
                    bank2_d = bcd_q;
                    over2_d = range_q;
                end else begin
                    bank1_d = bcd_q;
                    over1_d = range_q;
                end
                sel_d   = ~sel_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset release is expected to be synchronous to clk already, so no local synchronizer.
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            bin_q   <= 14'd0;
            bcd_q   <= 16'd0;
            range_q <= 1'b0;
            iter_q  <= 4'd0;
            bank1_q <= 16'd0;
            bank2_q <= 16'd0;
            over1_q <= 1'b0;
            over2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            range_q <= range_d;
            iter_q  <= iter_d;
            bank1_q <= bank1_d;
            bank2_q <= bank2_d;
            over1_q <= over1_d;
            over2_q <= over2_d;
        end
    end

    // A digit is blank when it and every higher digit of its group are zero; units always show.
    always_comb begin
        bankSel   = idx_q[2] ? bank2_q : bank1_q;
        overSel   = idx_q[2] ? over2_q : over1_q;
        digitPos  = idx_q[1:0];
        nibble    = 4'(bankSel >> {digitPos, 2'b00});
        upperZero = ((bankSel >> {digitPos, 2'b00}) == 16'd0);
        if (overSel)
            seg_d = 7'h3F;
        else if ((BLANK_LEADING != 0) && (digitPos != 2'd0) && upperZero)
            seg_d = 7'h7F;
        else
            seg_d = encodeDigit(nibble);
        an_d = ~(8'b1 << idx_q);
        dp_d = (idx_q != 3'd4);
    end

    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            seg_q   <= 7'h7F;
            an_q    <= 8'hFF;
            dp_q    <= 1'b1;
        end else begin
            if (presc_q == PRESC_MAX) begin
                presc_q <= '0;
                idx_q   <= idx_q + 3'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;
    assign dp_n  = dp_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux: instance A (SCAN_DIV=4, blanking on) and
// instance B (SCAN_DIV=1, blanking off) share the same inputs.
module tb_bcd_display_mux;

    logic        clk;
    logic        rst_ext_n;
    logic [13:0] number_1;
    logic [13:0] number_2;
    logic [6:0]  segA, segB;
    logic        dpA, dpB;
    logic [7:0]  anA, anB;

    int errors;
    int checks;
    int cyc;
    int relBase;
    int changeCyc;

    logic [6:0] capSeg [8];
    logic       capDp  [8];
    int         capCnt [8];

    bcd_display_mux #(.SCAN_DIV(4), .BLANK_LEADING(1)) dutA (
        .clk(clk), .rst_ext_n(rst_ext_n), .number_1(number_1), .number_2(number_2),
        .seg_n(segA), .dp_n(dpA), .an_n(anA)
    );

    bcd_display_mux #(.SCAN_DIV(1), .BLANK_LEADING(0)) dutB (
        .clk(clk), .rst_ext_n(rst_ext_n), .number_1(number_1), .number_2(number_2),
        .seg_n(segB), .dp_n(dpB), .an_n(anB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] n1, input logic [13:0] n2, input int settle);
        @(negedge clk);
        number_1 = n1;
        number_2 = n2;
        repeat (settle) @(posedge clk);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_ext_n = 1'b1;
        relBase   = cyc;
    endtask

    // Aligns to the start of digit 0 and records one full frame of the chosen instance.
    task automatic captureFrame(input int inst, input string tag);
        int         sd;
        logic [7:0] prevAn, curAn;
        logic       synced;
        sd     = (inst == 0) ? 4 : 1;
        synced = 1'b0;
        for (int i = 0; i < 8; i++) begin
            capSeg[i] = 7'h00;
            capDp[i]  = 1'b0;
            capCnt[i] = 0;
        end
        @(negedge clk);
        prevAn = (inst == 0) ? anA : anB;
        for (int t = 0; t < 20 * sd + 20; t++) begin
            @(negedge clk);
            curAn = (inst == 0) ? anA : anB;
            if (curAn == 8'hFE && prevAn != 8'hFE) begin
                synced = 1'b1;
                break;
            end
            prevAn = curAn;
        end
        checkOutput({tag, "_sync"}, {31'd0, synced}, 32'd1);
        if (synced) begin
            for (int j = 0; j < 8 * sd; j++) begin
                curAn = (inst == 0) ? anA : anB;
                for (int i = 0; i < 8; i++) begin
                    if (curAn == ~(8'b1 << i)) begin
                        capSeg[i] = (inst == 0) ? segA : segB;
                        capDp[i]  = (inst == 0) ? dpA : dpB;
                        capCnt[i]++;
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic checkFrame(input string tag, input int inst, input logic [55:0] expSeg);
        logic [7:0] dpBits;
        int         goodCnt;
        int         sd;
        sd = (inst == 0) ? 4 : 1;
        captureFrame(inst, tag);
        goodCnt = 0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("%s_d%0d", tag, i), {25'd0, capSeg[i]}, {25'd0, expSeg[i*7 +: 7]});
            dpBits[i] = capDp[i];
            if (capCnt[i] == sd) goodCnt++;
        end
        checkOutput({tag, "_dp"}, {24'd0, dpBits}, 32'h0000_00EF);
        checkOutput({tag, "_dwell"}, goodCnt, 32'd8);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        relBase   = 0;
        changeCyc = 0;
        rst_ext_n = 1'b0;
        number_1  = 14'd1234;
        number_2  = 14'd5678;

        // Reset values and the first cycle after release
        repeat (3) @(negedge clk);
        checkOutput("rst_segA", {25'd0, segA}, 32'h7F);
        checkOutput("rst_anA",  {24'd0, anA},  32'hFF);
        checkOutput("rst_dpA",  {31'd0, dpA},  32'h1);
        checkOutput("rst_anB",  {24'd0, anB},  32'hFF);
        releaseReset();
        @(negedge clk);
        checkOutput("first_anA",  {24'd0, anA},  32'hFE);
        checkOutput("first_segA", {25'd0, segA}, 32'h40);
        checkOutput("first_anB",  {24'd0, anB},  32'hFE);

        // Basic frame
        applyStimulus(14'd1234, 14'd0, 60);
        checkFrame("f1234A", 0, {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});
        checkFrame("f1234B", 1, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});

        // Range boundaries on number_1
        applyStimulus(14'd9999, 14'd0, 60);
        checkFrame("f9999A", 0, {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h10, 7'h10, 7'h10, 7'h10});
        applyStimulus(14'd10000, 14'd0, 60);
        checkFrame("f10000A", 0, {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
        checkFrame("f10000B", 1, {7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
        applyStimulus(14'd16383, 14'd0, 60);
        checkFrame("f16383A", 0, {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
        applyStimulus(14'd0, 14'd0, 60);
        checkFrame("f0A", 0, {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Leading-zero blanking on and off
        applyStimulus(14'd0, 14'd7, 60);
        checkFrame("f7A", 0, {7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        checkFrame("f7B", 1, {7'h40, 7'h40, 7'h40, 7'h78, 7'h40, 7'h40, 7'h40, 7'h40});

        // Input change during SHIFT is held off until the next conversion of that number
        @(negedge clk);
        rst_ext_n = 1'b0;
        number_1  = 14'd1;
        number_2  = 14'd0;
        repeat (2) @(negedge clk);
        releaseReset();
        repeat (40) @(posedge clk);
        @(negedge clk);
        number_1  = 14'd42;
        changeCyc = cyc;
        checkFrame("hold1B", 1, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79});
        for (int t = 0; t < 200 && cyc < changeCyc + 51; t++) @(posedge clk);
        checkFrame("upd42B", 1, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24});

        // Asynchronous reset pulse mid-SHIFT and mid-digit
        applyStimulus(14'd42, 14'd7, 60);
        for (int t = 0; t < 40; t++) begin
            if (((cyc - relBase) % 17) == 8) break;
            @(posedge clk);
        end
        #2;
        rst_ext_n = 1'b0;
        #1;
        checkOutput("arst_segA", {25'd0, segA}, 32'h7F);
        checkOutput("arst_anA",  {24'd0, anA},  32'hFF);
        checkOutput("arst_dpA",  {31'd0, dpA},  32'h1);
        checkOutput("arst_anB",  {24'd0, anB},  32'hFF);
        @(negedge clk);
        releaseReset();
        @(negedge clk);
        checkOutput("clr_segA", {25'd0, segA}, 32'h40);
        checkOutput("clr_anA",  {24'd0, anA},  32'hFE);
        checkOutput("clr_segB", {25'd0, segB}, 32'h40);
        repeat (51) @(posedge clk);
        checkFrame("rec42A", 0, {7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h7F, 7'h19, 7'h24});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
